// File: rtl/trng_bit_harvester.sv
// TRNG bit harvester: gates raw metastable samples on a settled delay lock, debiases them
// (von Neumann), runs a repetition-count health test and packs bits into valid/ready words.
module trng_bit_harvester #(
    parameter int WORD_W     = 32,
    parameter int SETTLE_CYC = 64,
    parameter int REP_LIMIT  = 32,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  raw_bit,
    input  logic                  locked,
    input  logic                  delay_update,
    input  logic                  health_clr,
    output logic [WORD_W-1:0]     rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  health_fail,
    output logic                  harvesting,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int CNT_W = $clog2(WORD_W + 1);

    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);
    localparam logic [RUN_W-1:0] REP_MAX     = RUN_W'(REP_LIMIT);
    localparam logic [CNT_W-1:0] WORD_FULL   = CNT_W'(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_SETTLE,
        S_HARVEST,
        S_FAIL
    } state_e;

    state_e                  state_q, state_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic                    phase_q, phase_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic [WORD_W-1:0]       asm_q, asm_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    fail_q, fail_d;
    logic                    harv_q, harv_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;

    logic                    xfer;
    logic                    out_free;
    logic                    emit;
    logic                    rep_hit;
    logic [RUN_W-1:0]        run_next;
    logic [WORD_W-1:0]       asm_shift;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        state_d   = state_q;
        settle_d  = settle_q;
        phase_d   = phase_q;
        first_d   = first_q;
        last_d    = last_q;
        run_d     = run_q;
        asm_d     = asm_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        drop_d    = drop_q;
        emit      = 1'b0;
        rep_hit   = 1'b0;
        run_next  = run_q;
        asm_shift = WORD_W'({first_q, asm_q} >> 1);

        xfer     = valid_q && rnd_ready;
        out_free = !valid_q || rnd_ready;
        if (xfer) valid_d = 1'b0;

        if (state_q == S_HARVEST) begin
            if (run_q != '0 && raw_bit == last_q)
                run_next = (run_q == REP_MAX) ? REP_MAX : run_q + 1'b1;
            else
                run_next = RUN_W'(1);
            rep_hit = (run_next == REP_MAX);
            run_d   = run_next;
            last_d  = raw_bit;
            phase_d = !phase_q;
            if (!phase_q) first_d = raw_bit;
            else          emit    = (first_q != raw_bit) && !rep_hit;

            // A full word parked in the assembly register blocks new bits until it moves out.
            if (bit_cnt_q == WORD_FULL) begin
                if (xfer) begin
                    data_d    = asm_q;
                    valid_d   = 1'b1;
                    bit_cnt_d = '0;
                end
                if (emit && drop_q != '1) drop_d = drop_q + 1'b1;
            end else if (emit) begin
                asm_d = asm_shift;
                if (bit_cnt_q == WORD_FULL - 1'b1) begin
                    if (out_free) begin
                        data_d    = asm_shift;
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = WORD_FULL;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE:      if (en) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: if (locked && !delay_update) begin
                             state_d  = S_SETTLE;
                             settle_d = SETTLE_LOAD;
                         end
            S_SETTLE:    if (!locked || delay_update) state_d = S_WAIT_LOCK;
                         else if (settle_q == '0)     state_d = S_HARVEST;
                         else                         settle_d = settle_q - 1'b1;
            S_HARVEST:   if (!locked || delay_update) state_d = S_WAIT_LOCK;
                         else if (rep_hit)            state_d = S_FAIL;
            S_FAIL:      if (health_clr) state_d = S_WAIT_LOCK;
            default:     state_d = S_IDLE;
        endcase
        if (!en) state_d = S_IDLE;

        if ((state_q == S_HARVEST && state_d != S_HARVEST) || state_d == S_IDLE) begin
            phase_d   = 1'b0;
            run_d     = '0;
            bit_cnt_d = '0;
            asm_d     = '0;
        end
        if (state_d == S_IDLE || state_d == S_FAIL) valid_d = 1'b0;

        fail_d = (state_d == S_FAIL);
        harv_d = (state_d == S_HARVEST);
    end

    // NOTE: sequential state uses non-blocking assignments only; the assembly register is reset like any other flop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            phase_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            run_q     <= '0;
            asm_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            harv_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            phase_q   <= phase_d;
            first_q   <= first_d;
            last_q    <= last_d;
            run_q     <= run_d;
            asm_q     <= asm_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fail_q    <= fail_d;
            harv_q    <= harv_d;
            drop_q    <= drop_d;
        end
    end

    assign rnd_data    = data_q;
    assign rnd_valid   = valid_q;
    assign health_fail = fail_q;
    assign harvesting  = harv_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_trng_bit_harvester.sv
// Scoreboard bench for trng_bit_harvester: a queue/arithmetic reference model predicts words
// and status flags; a posedge monitor pops expected words on every completed handshake.
module tb_trng_bit_harvester;

    localparam int WORD_W     = 8;
    localparam int SETTLE_CYC = 4;
    localparam int REP_LIMIT  = 32;
    localparam int DROP_CNT_W = 4;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_HARV   = 3;
    localparam int M_FAIL   = 4;

    logic                  clk = 1'b0;
    logic                  rstn, en, raw_bit, locked, delay_update, health_clr, rnd_ready;
    logic [WORD_W-1:0]     rnd_data;
    logic                  rnd_valid, health_fail, harvesting;
    logic [DROP_CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    trng_bit_harvester #(
        .WORD_W    (WORD_W),
        .SETTLE_CYC(SETTLE_CYC),
        .REP_LIMIT (REP_LIMIT),
        .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .raw_bit     (raw_bit),
        .locked      (locked),
        .delay_update(delay_update),
        .health_clr  (health_clr),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .health_fail (health_fail),
        .harvesting  (harvesting),
        .drop_cnt    (drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int                m_mode;
    int                m_settle_cnt;
    bit                m_pair[$];
    int                m_run;
    bit                m_last;
    bit                m_asm[$];
    bit                m_out_valid;
    int                m_drop;
    bit                model_live = 1'b0;
    bit                prev_rst   = 1'b0;
    logic [WORD_W-1:0] exp_q[$];

    function automatic logic [WORD_W-1:0] pack_word();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < WORD_W; i++) w[i] = m_asm[i];
        return w;
    endfunction

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int next_mode;
        int emitted;
        int run_new;
        bit xfer, nv, rep_hit;
        bit a;
        if (!rstn) begin
            m_mode = M_IDLE; m_settle_cnt = 0; m_pair.delete(); m_run = 0;
            m_asm.delete(); m_out_valid = 0; m_drop = 0; exp_q.delete();
            model_live = 1'b1; prev_rst = 1'b1;
            return;
        end
        prev_rst  = 1'b0;
        xfer      = m_out_valid && rnd_ready;
        nv        = m_out_valid && !xfer;
        next_mode = m_mode;
        rep_hit   = 1'b0;
        emitted   = -1;
        case (m_mode)
            M_IDLE: if (en) next_mode = M_WAIT;
            M_WAIT: if (locked && !delay_update) begin
                next_mode    = M_SETTLE;
                m_settle_cnt = 0;
            end
            M_SETTLE: if (!locked || delay_update) next_mode = M_WAIT;
                else begin
                    m_settle_cnt++;
                    if (m_settle_cnt == SETTLE_CYC) next_mode = M_HARV;
                end
            M_HARV: begin
                run_new = (m_run > 0 && raw_bit == m_last) ? m_run + 1 : 1;
                if (run_new > REP_LIMIT) run_new = REP_LIMIT;
                m_run   = run_new;
                m_last  = raw_bit;
                rep_hit = (run_new >= REP_LIMIT);
                if (m_pair.size() == 0) m_pair.push_back(raw_bit);
                else begin
                    a = m_pair.pop_front();
                    if (a != raw_bit && !rep_hit) emitted = int'(a);
                end
                if (m_asm.size() == WORD_W) begin
                    if (xfer) begin
                        exp_q.push_back(pack_word());
                        nv = 1'b1;
                        m_asm.delete();
                    end
                    if (emitted >= 0 && m_drop < (1 << DROP_CNT_W) - 1) m_drop++;
                end else if (emitted >= 0) begin
                    m_asm.push_back(emitted[0]);
                    if (m_asm.size() == WORD_W && (!m_out_valid || xfer)) begin
                        exp_q.push_back(pack_word());
                        nv = 1'b1;
                        m_asm.delete();
                    end
                end
                if (!locked || delay_update) next_mode = M_WAIT;
                else if (rep_hit)            next_mode = M_FAIL;
            end
            M_FAIL: if (health_clr) next_mode = M_WAIT;
            default: next_mode = M_IDLE;
        endcase
        if (!en) next_mode = M_IDLE;
        if ((m_mode == M_HARV && next_mode != M_HARV) || next_mode == M_IDLE) begin
            m_pair.delete();
            m_run = 0;
            m_asm.delete();
        end
        if (next_mode == M_IDLE || next_mode == M_FAIL) begin
            if (nv) void'(exp_q.pop_back());
            nv = 1'b0;
        end
        m_mode      = next_mode;
        m_out_valid = nv;
    endtask

    task automatic compare_outputs();
        if (!model_live) return;
        check("rnd_valid",   32'(rnd_valid),   32'(m_out_valid));
        check("harvesting",  32'(harvesting),  32'(m_mode == M_HARV));
        check("health_fail", 32'(health_fail), 32'(m_mode == M_FAIL));
        check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
        if (prev_rst) check("rnd_data_after_reset", 32'(rnd_data), 32'd0);
    endtask

    // One clock: compare the previous edge's outputs, apply new inputs, advance the model.
    task automatic cycle(input bit rn, input bit e, input bit r, input bit l,
                         input bit du, input bit hc, input bit rdy);
        @(negedge clk);
        compare_outputs();
        rstn = rn; en = e; raw_bit = r; locked = l;
        delay_update = du; health_clr = hc; rnd_ready = rdy;
        model_step();
    endtask

    // Monitor: every completed handshake must deliver the oldest predicted word.
    always @(posedge clk) begin
        if (rstn === 1'b1 && rnd_valid === 1'b1 && rnd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                failures++;
                checks++;
                $display("FAIL word_unexpected: got 0x%0h expected no word at %0t", rnd_data, $time);
            end else begin
                check("word", 32'(rnd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    bit patt_1001[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit stuck;
    int stuck_left;

    initial begin
        rstn = 1'b0; en = 1'b0; raw_bit = 1'b0; locked = 1'b0;
        delay_update = 1'b0; health_clr = 1'b0; rnd_ready = 1'b0;

        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);

        // Lock, settle, then raw 0,1 with the consumer stalled.
        for (int i = 0; i < 40; i++) cycle(1, 1, 1'(i % 2), 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0, 1);

        // Raw pairs 10,01 with the consumer always ready.
        for (int i = 0; i < 64; i++) cycle(1, 1, patt_1001[i % 4], 1, 0, 0, 1);

        // Stalled consumer: first word held, second parked, further bits dropped to saturation.
        for (int i = 0; i < 80; i++) cycle(1, 1, 1'((i + 1) % 2), 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1'(i % 2), 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 1, 0, 0, 1);

        // Repetition failure, then clear and relock.
        for (int i = 0; i < 40; i++) cycle(1, 1, 1, 1, 0, 0, 1);
        check("health_fail_latched", 32'(health_fail), 32'd1);
        cycle(1, 1, 0, 1, 0, 1, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 1'(i % 2), 1, 0, 0, 1);

        // delay_update mid-word discards the partial word.
        for (int i = 0; i < 40; i++) cycle(1, 1, 1'($urandom_range(0, 1)), 1, (i == 20), 0, 1);

        // Reset while a word is pending.
        for (int i = 0; i < 40; i++) cycle(1, 1, 1'($urandom_range(0, 1)), 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 1'(i % 2), 1, 0, 0, 1);

        // Randomised traffic including occasional stuck raw streams.
        stuck = 1'b0;
        stuck_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (stuck_left == 0 && $urandom_range(0, 149) == 0) begin
                stuck_left = $urandom_range(20, 40);
                stuck = 1'($urandom_range(0, 1));
            end
            if (stuck_left > 0) stuck_left--;
            cycle(($urandom_range(0, 499) != 0),
                  ($urandom_range(0, 199) != 0),
                  (stuck_left > 0) ? stuck : 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        // Drain: drop lock and accept everything still pending.
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        compare_outputs();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
